// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD sprite sequencer: FSM encoding, PCD8544
// init command bytes, panel geometry and address cursor commands.
// The optional clear pass is enabled by the LCD_CLEAR_EN macro in the top.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_CLEAR,
    ST_IDLE,
    ST_SETX,
    ST_SETY,
    ST_DATA,
    ST_DONE
  } state_t;

  localparam int unsigned LCD_COLS    = 84;
  localparam int unsigned LCD_BANKS   = 6;
  localparam int unsigned CLEAR_BYTES = LCD_COLS * LCD_BANKS;

  localparam logic [7:0] CMD_SETX = 8'h80;
  localparam logic [7:0] CMD_SETY = 8'h40;

  // Power-up command list: extended set, Vop, basic set, normal display
  localparam logic [7:0] INIT_EXT    = 8'h21;
  localparam logic [7:0] INIT_VOP    = 8'h90;
  localparam logic [7:0] INIT_BASIC  = 8'h20;
  localparam logic [7:0] INIT_NORMAL = 8'h0C;
  localparam int unsigned INIT_LEN   = 4;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = INIT_EXT;
      2'd1:    b = INIT_VOP;
      2'd2:    b = INIT_BASIC;
      default: b = INIT_NORMAL;
    endcase
    return b;
  endfunction

  // Address width holding 0..n*b*w so the look-ahead column never overflows
  function automatic int unsigned rom_addr_w(input int unsigned n,
                                             input int unsigned b,
                                             input int unsigned w);
    return $clog2(n * b * w + 1);
  endfunction

endpackage

// File: rtl/lcd_sprite_rom.sv
// Sprite bitmap ROM, combinational read. Layout: sprite-major, then bank,
// then column: addr = (id*SPRITE_BANKS + bank)*SPRITE_W + col.
// Contents are a fixed generated pattern; addresses past the table read 0.
module lcd_sprite_rom
  import lcd_pkg::*;
#(
  parameter int unsigned N_SPRITES    = 8,
  parameter int unsigned SPRITE_W     = 16,
  parameter int unsigned SPRITE_BANKS = 2,
  localparam int unsigned ADDR_W = rom_addr_w(N_SPRITES, SPRITE_BANKS, SPRITE_W)
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic [7:0]        o_data
);

  localparam int unsigned DEPTH = N_SPRITES * SPRITE_BANKS * SPRITE_W;

  // Bitmap lookup
  always_comb begin
    o_data = '0;
    if (32'(i_addr) < DEPTH) begin
      o_data = 8'(32'(i_addr) * 32'd37 + 32'd17);
    end
  end

endmodule

// File: rtl/lcd_sprite_sequencer.sv
// Sprite draw sequencer for an 84x48 PCD8544-style LCD behind a byte SPI
// master. Sends the init command list, optionally clears the panel, then
// draws sprites from lcd_sprite_rom bank by bank with column/bank clipping.
// One byte is presented per transfer and advanced on each spi_avail pulse.
// Macro LCD_CLEAR_EN: when defined, 504 zero data bytes follow init.
module lcd_sprite_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned N_SPRITES    = 8,
  parameter int unsigned SPRITE_W     = 16,
  parameter int unsigned SPRITE_BANKS = 2,
  parameter logic [15:0] DIV          = 16'd25000
) (
  input  logic                         clock,
  input  logic                         Reset,
  input  logic                         draw_req,
  input  logic [$clog2(N_SPRITES)-1:0] draw_id,
  input  logic [6:0]                   draw_x,
  input  logic [2:0]                   draw_bank,
  input  logic                         spi_avail,
  output logic [7:0]                   spi_data,
  output logic                         spi_cmd,
  output logic                         spi_start,
  output logic [15:0]                  spi_div,
  output logic                         busy,
  output logic                         done,
  output logic                         back
);

  localparam int unsigned ADDR_W = rom_addr_w(N_SPRITES, SPRITE_BANKS, SPRITE_W);
  localparam int unsigned ID_W   = $clog2(N_SPRITES);
  localparam int unsigned COL_W  = $clog2(SPRITE_W + 1);

  state_t            r_state;
  logic [8:0]        r_cnt;
  logic [ID_W-1:0]   r_id;
  logic [6:0]        r_x;
  logic [2:0]        r_bank;
  logic [2:0]        r_b;
  logic [COL_W-1:0]  r_col;
  logic [7:0]        r_data;
  logic              r_cmd;
  logic              r_start;
  logic              r_busy;
  logic              r_done;
  logic              r_back;

  logic [COL_W-1:0]  w_rom_col;
  logic [ADDR_W-1:0] w_rom_addr;
  logic [7:0]        w_rom_data;
  logic [7:0]        w_col_pos;
  logic              w_col_clip;
  logic              w_col_end;
  logic              w_bank_adv;
  logic [2:0]        w_b_next;
  logic              w_bank_stop;
  logic [7:0]        w_sety_byte;

  assign spi_data  = r_data;
  assign spi_cmd   = r_cmd;
  assign spi_start = r_start;
  assign spi_div   = DIV;
  assign busy      = r_busy;
  assign done      = r_done;
  assign back      = r_back;

  // Column of the next byte to present: 0 from SETY, col+1 while in DATA
  always_comb begin
    w_rom_col = '0;
    if (r_state == ST_DATA) begin
      w_rom_col = r_col + COL_W'(1);
    end
  end

  assign w_rom_addr = (ADDR_W'(r_id) * ADDR_W'(SPRITE_BANKS) + ADDR_W'(r_b))
                      * ADDR_W'(SPRITE_W) + ADDR_W'(w_rom_col);

  // Clip/advance decisions look ahead at the byte that would be sent next
  assign w_col_pos   = 8'(r_x) + 8'(w_rom_col);
  assign w_col_clip  = w_col_pos > 8'(LCD_COLS - 1);
  assign w_col_end   = (32'(w_rom_col) == SPRITE_W);
  assign w_bank_adv  = (r_state == ST_SETY) ? w_col_clip : (w_col_end || w_col_clip);
  assign w_b_next    = r_b + 3'd1;
  assign w_bank_stop = (32'(w_b_next) == SPRITE_BANKS) ||
                       ((4'(r_bank) + 4'(w_b_next)) > 4'(LCD_BANKS - 1));
  assign w_sety_byte = CMD_SETY | {5'b0, 3'(r_bank + r_b)};

  lcd_sprite_rom #(
    .N_SPRITES   (N_SPRITES),
    .SPRITE_W    (SPRITE_W),
    .SPRITE_BANKS(SPRITE_BANKS)
  ) u_rom (
    .i_addr(w_rom_addr),
    .o_data(w_rom_data)
  );

  // Sequencer FSM with registered SPI and status outputs
  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_id    <= '0;
      r_x     <= '0;
      r_bank  <= '0;
      r_b     <= '0;
      r_col   <= '0;
      r_data  <= '0;
      r_cmd   <= 1'b0;
      r_start <= 1'b0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_back  <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_INIT: begin
          if (!r_start) begin
            r_start <= 1'b1;
            r_cmd   <= 1'b0;
            r_data  <= init_cmd(r_cnt[1:0]);
          end else if (spi_avail) begin
            if (r_cnt == 9'(INIT_LEN - 1)) begin
              r_cnt <= '0;
`ifdef LCD_CLEAR_EN
              r_state <= ST_CLEAR;
              r_cmd   <= 1'b1;
              r_data  <= '0;
`else
              r_state <= ST_IDLE;
              r_start <= 1'b0;
              r_busy  <= 1'b0;
`endif
            end else begin
              r_cnt  <= r_cnt + 9'd1;
              r_data <= init_cmd(r_cnt[1:0] + 2'd1);
            end
          end
        end

        ST_CLEAR: begin
          if (spi_avail) begin
            if (r_cnt == 9'(CLEAR_BYTES - 1)) begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
              r_start <= 1'b0;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 9'd1;
            end
          end
        end

        ST_IDLE: begin
          if (draw_req && (32'(draw_id) < N_SPRITES)) begin
            r_id   <= draw_id;
            r_x    <= draw_x;
            r_bank <= draw_bank;
            r_b    <= '0;
            r_col  <= '0;
            r_busy <= 1'b1;
            r_back <= 1'b0;
            if (draw_bank > 3'(LCD_BANKS - 1)) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_SETX;
              r_start <= 1'b1;
              r_cmd   <= 1'b0;
              r_data  <= CMD_SETX | {1'b0, draw_x};
            end
          end
        end

        ST_SETX: begin
          if (spi_avail) begin
            r_state <= ST_SETY;
            r_data  <= w_sety_byte;
          end
        end

        // SETY and DATA share the "next column or next bank" decision
        ST_SETY, ST_DATA: begin
          if (spi_avail) begin
            if (w_bank_adv) begin
              r_b <= w_b_next;
              if (w_bank_stop) begin
                r_state <= ST_DONE;
                r_start <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= ST_SETX;
                r_cmd   <= 1'b0;
                r_data  <= CMD_SETX | {1'b0, r_x};
              end
            end else begin
              r_state <= ST_DATA;
              r_cmd   <= 1'b1;
              r_col   <= w_rom_col;
              r_data  <= w_rom_data;
            end
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_back  <= 1'b1;
        end

        default: begin
          r_state <= ST_INIT;
          r_cnt   <= '0;
          r_start <= 1'b0;
          r_busy  <= 1'b1;
          r_back  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_sprite_sequencer.sv
// Directed bench for lcd_sprite_sequencer (default parameters). A bus
// process pulses spi_avail every 4th cycle and records {cmd,data} of every
// byte the master accepts; each scenario compares that record to a list
// built from the expected command/ROM stream.
module tb_lcd_sprite_sequencer;

  logic        clock = 1'b0;
  logic        Reset = 1'b1;
  logic        draw_req = 1'b0;
  logic [2:0]  draw_id = '0;
  logic [6:0]  draw_x = '0;
  logic [2:0]  draw_bank = '0;
  logic        spi_avail = 1'b0;
  logic [7:0]  spi_data;
  logic        spi_cmd;
  logic        spi_start;
  logic [15:0] spi_div;
  logic        busy;
  logic        done;
  logic        back;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit avail_en = 1'b0;

  logic [8:0] got[$];
  logic [8:0] exp_q[$];

`ifdef LCD_CLEAR_EN
  localparam int CLR_BYTES = 504;
`else
  localparam int CLR_BYTES = 0;
`endif

  lcd_sprite_sequencer #(
    .N_SPRITES   (8),
    .SPRITE_W    (16),
    .SPRITE_BANKS(2),
    .DIV         (16'd25000)
  ) dut (
    .clock    (clock),
    .Reset    (Reset),
    .draw_req (draw_req),
    .draw_id  (draw_id),
    .draw_x   (draw_x),
    .draw_bank(draw_bank),
    .spi_avail(spi_avail),
    .spi_data (spi_data),
    .spi_cmd  (spi_cmd),
    .spi_start(spi_start),
    .spi_div  (spi_div),
    .busy     (busy),
    .done     (done),
    .back     (back)
  );

  always #5 clock = ~clock;

  // SPI master model: avail every 4th cycle, capture the byte it accepts
  initial begin : avail_gen
    int phase;
    phase = 0;
    forever begin
      @(negedge clock);
      phase = (phase + 1) % 4;
      if (avail_en && phase == 0) begin
        spi_avail = 1'b1;
        if (spi_start === 1'b1) got.push_back({spi_cmd, spi_data});
      end else begin
        spi_avail = 1'b0;
      end
    end
  end

  // Count cycles with done high
  initial begin : done_mon
    forever begin
      @(negedge clock);
      if (done === 1'b1) done_cnt++;
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] rom_model(input int a);
    return 8'(a * 37 + 17);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_stream(input string tag);
    int n;
    checks++;
    assert (got.size() === exp_q.size()) else begin
      errors++;
      $error("FAIL %s_len: got %0d bytes expected %0d", tag, got.size(), exp_q.size());
    end
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      assert (got[i] === exp_q[i]) else begin
        errors++;
        $error("FAIL %s_byte%0d: got %03h expected %03h", tag, i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    @(negedge clock);
  endtask

  task automatic exp_init();
    exp_q.delete();
    exp_q.push_back(9'h021);
    exp_q.push_back(9'h090);
    exp_q.push_back(9'h020);
    exp_q.push_back(9'h00C);
    for (int i = 0; i < CLR_BYTES; i++) exp_q.push_back(9'h100);
  endtask

  // Expected bytes for one bank: cursor commands, then visible columns
  task automatic exp_bank(input int id, input int x, input int bank, input int b);
    exp_q.push_back({1'b0, 8'h80 | 8'(x)});
    exp_q.push_back({1'b0, 8'h40 | 8'(bank + b)});
    for (int c = 0; c < 16; c++)
      if (x + c <= 83) exp_q.push_back({1'b1, rom_model((id * 2 + b) * 16 + c)});
  endtask

  task automatic req(input int id, input int x, input int bank);
    @(negedge clock);
    draw_req  = 1'b1;
    draw_id   = 3'(id);
    draw_x    = 7'(x);
    draw_bank = 3'(bank);
    @(negedge clock);
    draw_req  = 1'b0;
  endtask

  initial begin : main
    // Reset state
    Reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_start", 32'(spi_start), 32'd0);
    chk("rst_data",  32'(spi_data),  32'd0);
    chk("rst_cmd",   32'(spi_cmd),   32'd0);
    chk("rst_busy",  32'(busy),      32'd1);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_back",  32'(back),      32'd1);
    chk("spi_div",   32'(spi_div),   32'd25000);

    // Init (and optional clear) sequence
    Reset = 1'b0;
    avail_en = 1'b1;
    exp_init();
    wait_idle("init", 4000);
    check_stream("init");
    chk("idle_back", 32'(back), 32'd1);
    chk("idle_start", 32'(spi_start), 32'd0);
    chk("init_done", 32'(done_cnt), 32'd0);

    // Two-bank draw: id=1, x=10, bank=2
    got.delete(); exp_q.delete(); done_cnt = 0;
    exp_bank(1, 10, 2, 0);
    exp_bank(1, 10, 2, 1);
    req(1, 10, 2);
    chk("d1_busy", 32'(busy), 32'd1);
    chk("d1_back", 32'(back), 32'd0);
    wait_idle("d1", 1000);
    chk("d1_done_cycles", 32'(done_cnt), 32'd1);
    chk("d1_back_after", 32'(back), 32'd1);
    check_stream("d1");

    // Column clip: x=80 leaves 4 visible columns per bank
    got.delete(); exp_q.delete(); done_cnt = 0;
    exp_bank(0, 80, 0, 0);
    exp_bank(0, 80, 0, 1);
    req(0, 80, 0);
    wait_idle("d2", 1000);
    chk("d2_done_cycles", 32'(done_cnt), 32'd1);
    check_stream("d2");

    // Bank clip at bank 5, with a request during busy that must be dropped
    got.delete(); exp_q.delete(); done_cnt = 0;
    exp_bank(2, 0, 5, 0);
    req(2, 0, 5);
    repeat (3) @(negedge clock);
    chk("d3_busy_at_req2", 32'(busy), 32'd1);
    req(0, 0, 0);
    wait_idle("d3", 1000);
    repeat (40) @(negedge clock);
    chk("d3_done_cycles", 32'(done_cnt), 32'd1);
    chk("d3_still_idle", 32'(busy), 32'd0);
    check_stream("d3");

    // Reset in the middle of sprite data
    got.delete(); exp_q.delete(); done_cnt = 0;
    req(1, 10, 2);
    begin : find_data
      int n;
      n = 0;
      while (!(spi_cmd === 1'b1 && spi_start === 1'b1) && n < 500) begin
        @(negedge clock);
        n++;
      end
    end
    chk("mid_in_data", 32'(spi_cmd), 32'd1);
    chk("mid_back", 32'(back), 32'd0);
    avail_en = 1'b0;
    Reset = 1'b1;
    #1;
    chk("mid_rst_start", 32'(spi_start), 32'd0);
    chk("mid_rst_busy",  32'(busy),      32'd1);
    chk("mid_rst_back",  32'(back),      32'd1);
    got.delete();
    done_cnt = 0;
    repeat (3) @(negedge clock);
    Reset = 1'b0;
    avail_en = 1'b1;
    exp_init();
    wait_idle("restart", 4000);
    check_stream("restart");
    chk("restart_done", 32'(done_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
